// File: rtl/cap_req_stage.sv
// Capability-checked request stage: accepts one request, has an external checker
// vet it against the latched capability, then issues it to memory or raises a fault.
module cap_req_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_kind,
   input  logic [31:0] req_wdata,
   input  logic        cap_tag,
   input  logic [31:0] cap_base,
   input  logic [31:0] cap_length,
   input  logic [2:0]  cap_perm,
   output logic        chk_tag,
   output logic [31:0] chk_base,
   output logic [31:0] chk_length,
   output logic [31:0] chk_addr,
   output logic        chk_need_load,
   output logic        chk_need_store,
   output logic        chk_need_exec,
   output logic        chk_perm_load,
   output logic        chk_perm_store,
   output logic        chk_perm_exec,
   input  logic        chk_ok,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   output logic        fault,
   output logic [31:0] fault_addr,
   output logic [1:0]  fault_kind,
   output logic [7:0]  fault_count,
   input  logic        fault_clr
);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_FAULT} state_t;

   state_t      state_q;
   logic [31:0] addr_q, wdata_q, base_q, len_q;
   logic [1:0]  kind_q;
   logic        tag_q;
   logic [2:0]  perm_q;
   logic [2:0]  need_q;
   logic        req_ready_q, mem_valid_q, fault_q;
   logic [31:0] faddr_q, faddr_d;
   logic [1:0]  fkind_q, fkind_d;
   logic [7:0]  fcount_q, fcount_d;
   logic        enter_fault;

   // Reserved kinds fault straight from IDLE using the incoming payload;
   // checker rejections fault from CHECK using the latched copy.
   always_comb begin
      enter_fault = ((state_q == S_IDLE) && req_valid && (req_kind == 2'b11)) ||
                    ((state_q == S_CHECK) && !chk_ok);
      faddr_d     = (state_q == S_IDLE) ? req_addr : addr_q;
      fkind_d     = (state_q == S_IDLE) ? req_kind : kind_q;
      fcount_d    = (fcount_q == 8'hFF) ? fcount_q : fcount_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         base_q      <= '0;
         len_q       <= '0;
         kind_q      <= '0;
         tag_q       <= 1'b0;
         perm_q      <= '0;
         need_q      <= '0;
         req_ready_q <= 1'b1;
         mem_valid_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  base_q      <= cap_base;
                  len_q       <= cap_length;
                  kind_q      <= req_kind;
                  tag_q       <= cap_tag;
                  perm_q      <= cap_perm;
                  req_ready_q <= 1'b0;
                  if (req_kind == 2'b11) begin
                     state_q <= S_FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     state_q <= S_CHECK;
                     need_q  <= {req_kind == 2'b10, req_kind == 2'b01, req_kind == 2'b00};
                  end
               end
            end
            S_CHECK: begin
               need_q <= '0;
               if (chk_ok) begin
                  state_q     <= S_ISSUE;
                  mem_valid_q <= 1'b1;
               end else begin
                  state_q <= S_FAULT;
                  fault_q <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (mem_ready) begin
                  state_q     <= S_IDLE;
                  mem_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            S_FAULT: begin
               if (fault_clr) begin
                  state_q     <= S_IDLE;
                  fault_q     <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         faddr_q  <= '0;
         fkind_q  <= '0;
         fcount_q <= '0;
      end else if (enter_fault) begin
         faddr_q  <= faddr_d;
         fkind_q  <= fkind_d;
         fcount_q <= fcount_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign chk_tag        = tag_q;
   assign chk_base       = base_q;
   assign chk_length     = len_q;
   assign chk_addr       = addr_q;
   assign chk_need_load  = need_q[0];
   assign chk_need_store = need_q[1];
   assign chk_need_exec  = need_q[2];
   assign chk_perm_load  = perm_q[0];
   assign chk_perm_store = perm_q[1];
   assign chk_perm_exec  = perm_q[2];
   assign mem_valid      = mem_valid_q;
   assign mem_addr       = addr_q;
   assign mem_we         = (kind_q == 2'b01);
   assign mem_wdata      = wdata_q;
   assign fault          = fault_q;
   assign fault_addr     = faddr_q;
   assign fault_kind     = fkind_q;
   assign fault_count    = fcount_q;

endmodule

// File: tb/tb_cap_req_stage.sv
// Bench for cap_req_stage: plays the capability checker and memory, and compares the
// design every cycle against a request-level model plus hand-computed literals.
module tb_cap_req_stage;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_kind;
   logic        cap_tag;
   logic [31:0] cap_base, cap_length;
   logic [2:0]  cap_perm;
   logic        chk_tag;
   logic [31:0] chk_base, chk_length, chk_addr;
   logic        chk_need_load, chk_need_store, chk_need_exec;
   logic        chk_perm_load, chk_perm_store, chk_perm_exec;
   logic        chk_ok;
   logic        mem_valid, mem_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        fault, fault_clr;
   logic [31:0] fault_addr;
   logic [1:0]  fault_kind;
   logic [7:0]  fault_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cap_req_stage dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_kind(req_kind), .req_wdata(req_wdata),
      .cap_tag(cap_tag), .cap_base(cap_base), .cap_length(cap_length), .cap_perm(cap_perm),
      .chk_tag(chk_tag), .chk_base(chk_base), .chk_length(chk_length), .chk_addr(chk_addr),
      .chk_need_load(chk_need_load), .chk_need_store(chk_need_store), .chk_need_exec(chk_need_exec),
      .chk_perm_load(chk_perm_load), .chk_perm_store(chk_perm_store), .chk_perm_exec(chk_perm_exec),
      .chk_ok(chk_ok), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .fault(fault), .fault_addr(fault_addr),
      .fault_kind(fault_kind), .fault_count(fault_count), .fault_clr(fault_clr)
   );

   // Capability rule: valid tag, a 4-byte access fully inside [base, base+len), permission for the kind.
   function automatic logic cap_allows(input logic tag, input logic [31:0] base, input logic [31:0] len,
                                       input logic [31:0] addr, input logic [1:0] kind, input logic [2:0] perm);
      logic [33:0] lo, hi, a;
      logic        p;
      lo = {2'b00, base};
      hi = {2'b00, base} + {2'b00, len};
      a  = {2'b00, addr};
      p  = (kind == 2'd0) ? perm[0] : (kind == 2'd1) ? perm[1] : (kind == 2'd2) ? perm[2] : 1'b0;
      return tag && (a >= lo) && (a + 34'd4 <= hi) && p;
   endfunction

   // The bench acts as the external checker, judging whatever the design presents.
   logic [1:0] shown_kind;
   assign shown_kind = chk_need_store ? 2'd1 : chk_need_exec ? 2'd2 : 2'd0;
   assign chk_ok = (chk_need_load | chk_need_store | chk_need_exec) &&
                   cap_allows(chk_tag, chk_base, chk_length, chk_addr, shown_kind,
                              {chk_perm_exec, chk_perm_store, chk_perm_load});

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Request-level model: one outstanding request, which is either awaiting its verdict,
   // owed to memory, or parked as a fault until cleared.
   bit          m_live = 0, m_await = 0, m_owed = 0, m_parked = 0;
   logic [31:0] m_addr, m_wdata, m_base, m_len, m_faddr;
   logic [1:0]  m_kind, m_fkind;
   logic        m_tag;
   logic [2:0]  m_perm;
   int          m_nfaults;

   always @(posedge clk) begin
      if (rst) begin
         m_live = 1; m_await = 0; m_owed = 0; m_parked = 0;
         m_addr = 0; m_wdata = 0; m_base = 0; m_len = 0; m_kind = 0; m_tag = 0; m_perm = 0;
         m_faddr = 0; m_fkind = 0; m_nfaults = 0;
      end else if (m_parked) begin
         if (fault_clr) m_parked = 0;
      end else if (m_owed) begin
         if (mem_ready) m_owed = 0;
      end else if (m_await) begin
         m_await = 0;
         if (cap_allows(m_tag, m_base, m_len, m_addr, m_kind, m_perm)) m_owed = 1;
         else begin m_parked = 1; m_faddr = m_addr; m_fkind = m_kind; m_nfaults++; end
      end else if (req_valid) begin
         m_addr = req_addr; m_wdata = req_wdata; m_kind = req_kind; m_base = cap_base;
         m_len = cap_length; m_tag = cap_tag; m_perm = cap_perm;
         if (req_kind == 2'b11) begin m_parked = 1; m_faddr = req_addr; m_fkind = req_kind; m_nfaults++; end
         else m_await = 1;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("req_ready", 32'(req_ready), 32'(!(m_await || m_owed || m_parked)));
         check("mem_valid", 32'(mem_valid), 32'(m_owed));
         if (m_owed) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_we", 32'(mem_we), 32'(m_kind == 2'd1));
            check("mem_wdata", mem_wdata, m_wdata);
         end
         check("fault", 32'(fault), 32'(m_parked));
         check("fault_addr", fault_addr, m_faddr);
         check("fault_kind", 32'(fault_kind), 32'(m_fkind));
         check("fault_count", 32'(fault_count), (m_nfaults > 255) ? 32'd255 : 32'(m_nfaults));
         check("chk_need", 32'({chk_need_exec, chk_need_store, chk_need_load}),
               32'({m_await && m_kind == 2'd2, m_await && m_kind == 2'd1, m_await && m_kind == 2'd0}));
         check("chk_addr", chk_addr, m_addr);
         check("chk_base", chk_base, m_base);
         check("chk_length", chk_length, m_len);
         check("chk_tag", 32'(chk_tag), 32'(m_tag));
         check("chk_perm", 32'({chk_perm_exec, chk_perm_store, chk_perm_load}), 32'(m_perm));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [1:0] k, input logic [31:0] wd,
                        input logic t, input logic [31:0] b, input logic [31:0] l, input logic [2:0] p);
      req_addr = a; req_kind = k; req_wdata = wd;
      cap_tag = t; cap_base = b; cap_length = l; cap_perm = p;
      req_valid = 1'b1;
   endtask

   // Runs one request to completion; memory withholds ready for 'hold' issue cycles.
   task automatic do_req(input logic [31:0] a, input logic [1:0] k, input logic [31:0] wd,
                         input logic t, input logic [31:0] b, input logic [31:0] l,
                         input logic [2:0] p, input int unsigned hold);
      int unsigned seen;
      seen = 0;
      mem_ready = 1'b0;
      drive(a, k, wd, t, b, l, p);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (fault) begin
            fault_clr = 1'b1;
            tick();
            fault_clr = 1'b0;
            return;
         end
         if (req_ready) return;
         if (mem_valid) begin
            mem_ready = (seen >= hold);
            seen++;
         end
         tick();
      end
      n_checks++;
      n_errors++;
      $display("FAIL do_req_timeout: got no completion expected completion within 40 cycles");
   endtask

   typedef struct {
      logic [31:0] a; logic [1:0] k; logic [31:0] wd; logic t;
      logic [31:0] b; logic [31:0] l; logic [2:0] p; int unsigned hold;
   } vec_t;
   vec_t vecs[7];

   initial begin
      vecs[0] = '{32'h2000, 2'd0, 32'h0,        1'b1, 32'h2000, 32'h10,  3'b001, 0}; // load, first word
      vecs[1] = '{32'h2004, 2'd1, 32'h1234,     1'b1, 32'h2000, 32'h10,  3'b001, 0}; // store without perm
      vecs[2] = '{32'h3000, 2'd2, 32'h0,        1'b1, 32'h3000, 32'h40,  3'b100, 1}; // exec
      vecs[3] = '{32'h1004, 2'd0, 32'h0,        1'b0, 32'h1000, 32'h100, 3'b111, 0}; // untagged
      vecs[4] = '{32'h0FFC, 2'd0, 32'h0,        1'b1, 32'h1000, 32'h100, 3'b001, 0}; // below base
      vecs[5] = '{32'h10FC, 2'd0, 32'h0,        1'b1, 32'h1000, 32'h100, 3'b001, 2}; // last word
      vecs[6] = '{32'h1000, 2'd1, 32'hCAFEF00D, 1'b1, 32'h1000, 32'h100, 3'b010, 1}; // store

      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_kind = '0; req_wdata = '0;
      cap_tag = 1'b0; cap_base = '0; cap_length = '0; cap_perm = '0;
      mem_ready = 1'b0; fault_clr = 1'b0;
      tick(); tick();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_fault_count", 32'(fault_count), 32'd0);
      check("rst_need", 32'({chk_need_exec, chk_need_store, chk_need_load}), 32'd0);
      rst = 1'b0;
      tick();

      // Legal load; fault_clr held high must be ignored outside a fault.
      mem_ready = 1'b1; fault_clr = 1'b1;
      drive(32'h1004, 2'd0, 32'h0, 1'b1, 32'h1000, 32'h100, 3'b001);
      tick();
      req_valid = 1'b0;
      check("load_need_load", 32'(chk_need_load), 32'd1);
      check("load_ready_busy", 32'(req_ready), 32'd0);
      tick();
      check("load_mem_valid", 32'(mem_valid), 32'd1);
      check("load_mem_addr", mem_addr, 32'h1004);
      check("load_mem_we", 32'(mem_we), 32'd0);
      tick();
      check("load_done_ready", 32'(req_ready), 32'd1);
      fault_clr = 1'b0;

      // Bounds fault: 4-byte access at 0x10FE overruns the 0x1100 limit.
      drive(32'h10FE, 2'd0, 32'h0, 1'b1, 32'h1000, 32'h100, 3'b001);
      tick();
      req_valid = 1'b0;
      tick();
      check("bnd_fault", 32'(fault), 32'd1);
      check("bnd_mem_valid", 32'(mem_valid), 32'd0);
      check("bnd_fault_addr", fault_addr, 32'h10FE);
      check("bnd_fault_kind", 32'(fault_kind), 32'd0);
      check("bnd_fault_count", 32'(fault_count), 32'd1);
      tick();
      check("bnd_fault_hold", 32'(fault), 32'd1);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("bnd_clr_fault", 32'(fault), 32'd0);
      check("bnd_clr_ready", 32'(req_ready), 32'd1);
      check("bnd_keep_addr", fault_addr, 32'h10FE);

      // Backpressure on a store.
      mem_ready = 1'b0;
      drive(32'h1010, 2'd1, 32'hDEADBEEF, 1'b1, 32'h1000, 32'h100, 3'b010);
      tick();
      req_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_mem_valid", 32'(mem_valid), 32'd1);
         check("bp_mem_addr", mem_addr, 32'h1010);
         check("bp_mem_wdata", mem_wdata, 32'hDEADBEEF);
         check("bp_mem_we", 32'(mem_we), 32'd1);
         tick();
      end
      check("bp_still_valid", 32'(mem_valid), 32'd1);
      mem_ready = 1'b1;
      tick();
      check("bp_done_valid", 32'(mem_valid), 32'd0);
      check("bp_done_ready", 32'(req_ready), 32'd1);

      // Reserved kind faults on the very next edge without engaging the checker.
      drive(32'h5555_0000, 2'd3, 32'h0, 1'b1, 32'h1000, 32'h100, 3'b111);
      tick();
      req_valid = 1'b0;
      check("rsv_fault", 32'(fault), 32'd1);
      check("rsv_fault_kind", 32'(fault_kind), 32'd3);
      check("rsv_fault_addr", fault_addr, 32'h5555_0000);
      check("rsv_need", 32'({chk_need_exec, chk_need_store, chk_need_load}), 32'd0);
      check("rsv_fault_count", 32'(fault_count), 32'd2);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;

      foreach (vecs[i])
         do_req(vecs[i].a, vecs[i].k, vecs[i].wd, vecs[i].t, vecs[i].b, vecs[i].l, vecs[i].p, vecs[i].hold);

      // Saturation: enough faults to push the counter well past 255.
      for (int n = 0; n < 260; n++)
         do_req(32'(n), 2'd3, 32'h0, 1'b1, 32'h0, 32'h0, 3'b000, 0);
      check("sat_fault_count", 32'(fault_count), 32'd255);

      // Reset while a request is stalled in issue.
      mem_ready = 1'b0;
      drive(32'h1020, 2'd0, 32'h0, 1'b1, 32'h1000, 32'h100, 3'b001);
      tick();
      req_valid = 1'b0;
      tick(); tick();
      check("rstiss_pre_valid", 32'(mem_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstiss_mem_valid", 32'(mem_valid), 32'd0);
      check("rstiss_ready", 32'(req_ready), 32'd1);
      check("rstiss_fault_count", 32'(fault_count), 32'd0);
      tick(); tick();
      check("rstiss_no_reissue", 32'(mem_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cap_req_stage.md
CAP_REQ_STAGE -- requirements
Module: cap_req_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports req_valid in 1, req_ready out 1  request handshake; a transfer occurs when both are 1 on a rising edge.
REQ-004 SHALL have ports req_addr in 32, req_kind in 2, req_wdata in 32  request payload; req_kind encoding: 00 load, 01 store, 10 exec, 11 reserved.
REQ-005 SHALL have ports cap_tag in 1, cap_base in 32, cap_length in 32, cap_perm in 3  capability for the request; cap_perm bits are [0] load, [1] store, [2] exec.
REQ-006 SHALL have ports chk_tag out 1, chk_base out 32, chk_length out 32, chk_addr out 32, chk_need_load/chk_need_store/chk_need_exec out 1 each, chk_perm_load/chk_perm_store/chk_perm_exec out 1 each  drive the combinational capability checker.
REQ-007 SHALL have port chk_ok  in  1  checker verdict, valid in the same cycle as the chk_* outputs.
REQ-008 SHALL have ports mem_valid out 1, mem_ready in 1, mem_addr out 32, mem_we out 1, mem_wdata out 32  downstream memory request handshake.
REQ-009 SHALL have ports fault out 1, fault_addr out 32, fault_kind out 2, fault_count out 8, fault_clr in 1  fault reporting.

Function
REQ-010 SHALL implement a four-state FSM with states IDLE, CHECK, ISSUE and FAULT.
REQ-011 IDLE SHALL drive req_ready=1; on a transfer, SHALL latch addr, kind, wdata and the capability fields, then go to CHECK, or go to FAULT if kind is 11.
REQ-012 The chk_* data outputs SHALL always reflect the latched registers.
REQ-013 chk_need_* SHALL be 0 outside CHECK; in CHECK, exactly the one bit matching the latched kind SHALL be 1.
REQ-014 CHECK SHALL last exactly one cycle: chk_ok=1 goes to ISSUE; chk_ok=0 goes to FAULT.
REQ-015 ISSUE SHALL drive mem_valid=1, with mem_addr, mem_wdata and mem_we (1 only for store) held stable until mem_ready=1, then go to IDLE.
REQ-016 Latency: for a transfer on edge N, CHECK SHALL be active in cycle N+1 and mem_valid SHALL first be 1 in cycle N+2; maximum throughput is one request per 3 cycles.
REQ-017 On entry to FAULT, fault_addr and fault_kind SHALL capture the latched addr and kind, and fault_count SHALL increment, saturating at 255.
REQ-018 FAULT SHALL drive fault=1 and req_ready=0, hold until fault_clr=1, then return to IDLE with fault=0 on the next cycle.
REQ-019 fault_addr and fault_kind SHALL retain their values after clearing, until the next fault or reset.
REQ-020 fault_clr SHALL be ignored in any state other than FAULT.
REQ-021 req_ready SHALL be 0 in CHECK, ISSUE and FAULT, so no request is accepted while one is outstanding.
REQ-022 mem_valid SHALL never be asserted for a request that received chk_ok=0 or had kind 11.
REQ-023 mem_valid, once asserted, SHALL not deassert before mem_ready, except on rst.

Reset
REQ-024 rst SHALL take precedence over all other inputs and SHALL force IDLE at the next edge.
REQ-025 Reset values SHALL be: req_ready=1 (IDLE), mem_valid=0, fault=0, fault_addr=0, fault_kind=0, fault_count=0, all latched registers 0, chk_need_*=0.
REQ-026 rst asserted in ISSUE SHALL drop mem_valid on the next cycle; the request is abandoned and not reissued.

Verification
REQ-027 Legal load: addr 0x1004, cap tag=1 base 0x1000 len 0x100 perm 001, chk_ok=1 -> mem_valid at N+2, mem_addr 0x1004, mem_we 0.
REQ-028 Bounds fault: addr 0x10FE, same cap, chk_ok=0 -> no mem_valid, fault=1 at N+2, fault_addr 0x10FE, fault_kind 00, fault_count 1; fault_clr -> IDLE, req_ready=1.
REQ-029 Backpressure: legal store with wdata 0xDEADBEEF, mem_ready held 0 for 5 cycles -> mem_valid, addr and wdata stable with mem_we=1, completes on the cycle mem_ready=1.
REQ-030 Reserved kind 11 -> FAULT on the next edge with chk_need_* all 0 throughout and fault_kind 11.
REQ-031 Saturation: 260 faulting requests, each cleared -> fault_count reads 255.
REQ-032 Reset mid-ISSUE with mem_ready=0 -> mem_valid=0 and req_ready=1 the cycle after rst; fault_count 0.
